// File: rtl/program_counter_stack_pkg.sv
// Shared constants and helpers for the program counter / return stack.
// Command encoding, the default address width and a width helper.
package program_counter_stack_pkg;

    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        CMD_HOLD = 3'd0,
        CMD_INCR = 3'd1,
        CMD_JUMP = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4
    } cmd_e;

    // ceil(log2(n)), never below 1 so a port width is always legal
    function automatic int clog2_f(input int n);
        int w;
        w = 0;
        while ((1 << w) < n)
            w++;
        return (w < 1) ? 1 : w;
    endfunction

    // ret beats call beats jump beats incr; the losers are dropped
    function automatic cmd_e decode_cmd(
        input logic incr,
        input logic jump,
        input logic call,
        input logic ret
    );
        if (ret)
            return CMD_RET;
        else if (call)
            return CMD_CALL;
        else if (jump)
            return CMD_JUMP;
        else if (incr)
            return CMD_INCR;
        else
            return CMD_HOLD;
    endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Command and status bundle between a sequencer and the pc/stack block.
// The master issues commands; the slave reports pc and stack status.
interface program_counter_stack_if
    import program_counter_stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = clog2_f(DEPTH + 1)
) ();

    logic              incr;
    logic              jump;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;

    logic [ADDR_W-1:0] pc;
    logic [LVL_W-1:0]  level;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output incr, jump, call, ret, target,
        input  pc, level, full, empty, overflow, underflow
    );

    modport slave (
        input  incr, jump, call, ret, target,
        output pc, level, full, empty, overflow, underflow
    );

endinterface

// File: rtl/program_counter_stack_stack.sv
// Return-address LIFO with its level counter.
// Entry storage is not reset; only the level decides what is valid.
module pc_stack
    import program_counter_stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = clog2_f(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetBar,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] top,
    output logic [LVL_W-1:0]  level
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic              is_full;
    logic              is_empty;
    logic              do_push;
    logic              do_pop;

    assign is_full  = (level == LVL_W'(DEPTH));
    assign is_empty = (level == '0);
    assign do_pop   = pop && !is_empty;
    assign do_push  = push && !pop && !is_full;

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar)
            level <= '0;
        else if (do_pop)
            level <= level - 1'b1;
        else if (do_push)
            level <= level + 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && level == LVL_W'(i))
                mem[i] <= data_in;
        end
    end

    // Only the entry just below level is ever presented
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level == LVL_W'(i + 1))
                top = mem[i];
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with call/return stack and sticky error flags.
// Priority decode and the pc register live here; the LIFO is pc_stack.
module program_counter_stack
    import program_counter_stack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = clog2_f(DEPTH + 1)
) (
    input  logic clk,
    input  logic resetBar,
    program_counter_stack_if.slave bus
);

    cmd_e              cmd;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] stk_top;
    logic [LVL_W-1:0]  stk_level;
    logic              stk_push;
    logic              stk_pop;
    logic              is_full;
    logic              is_empty;
    logic              ovf_q;
    logic              unf_q;
    logic              ovf_set;
    logic              unf_set;

    assign cmd      = decode_cmd(bus.incr, bus.jump, bus.call, bus.ret);
    assign pc_inc   = pc_q + 1'b1;
    assign is_full  = (stk_level == LVL_W'(DEPTH));
    assign is_empty = (stk_level == '0);

    always_comb begin
        pc_nxt   = pc_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        unique case (cmd)
            CMD_INCR: pc_nxt = pc_inc;
            CMD_JUMP: pc_nxt = bus.target;
            CMD_CALL: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    stk_push = 1'b1;
                    pc_nxt   = bus.target;
                end
            end
            CMD_RET: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    pc_nxt  = stk_top;
                end
            end
            default: pc_nxt = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

    // Return address is the instruction after the call
    pc_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_stack (
        .clk      (clk),
        .resetBar (resetBar),
        .push     (stk_push),
        .pop      (stk_pop),
        .data_in  (pc_inc),
        .top      (stk_top),
        .level    (stk_level)
    );

    assign bus.pc        = pc_q;
    assign bus.level     = stk_level;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench for program_counter_stack (ADDR_W=8, DEPTH=4).
// A reference model queues expected state per command; compared after the edge.
module tb_program_counter_stack;

    localparam int AW = 8;
    localparam int DP = 4;
    localparam int LW = 3;

    typedef struct {
        logic [AW-1:0] pc;
        logic [LW-1:0] lvl;
        logic          f;
        logic          e;
        logic          o;
        logic          u;
    } exp_t;

    logic clk;
    logic resetBar;
    int   n_checks;
    int   n_fail;

    exp_t          sbq[$];
    logic [AW-1:0] m_pc;
    int            m_lvl;
    logic [AW-1:0] m_stk [DP];
    logic          m_ovf;
    logic          m_unf;

    program_counter_stack_if #(.ADDR_W(AW), .DEPTH(DP), .LVL_W(LW)) bif ();

    program_counter_stack #(
        .ADDR_W (AW),
        .DEPTH  (DP),
        .LVL_W  (LW)
    ) dut (
        .clk      (clk),
        .resetBar (resetBar),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_lvl = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic exp_t model_snap();
        exp_t x;
        x.pc  = m_pc;
        x.lvl = LW'(m_lvl);
        x.f   = (m_lvl == DP);
        x.e   = (m_lvl == 0);
        x.o   = m_ovf;
        x.u   = m_unf;
        return x;
    endfunction

    task automatic compare_now(input string tag, input exp_t x);
        chk({tag, ".pc"},  32'(bif.pc),    32'(x.pc));
        chk({tag, ".lvl"}, 32'(bif.level), 32'(x.lvl));
        chk({tag, ".full"},  32'(bif.full),      32'(x.f));
        chk({tag, ".empty"}, 32'(bif.empty),     32'(x.e));
        chk({tag, ".ovf"},   32'(bif.overflow),  32'(x.o));
        chk({tag, ".unf"},   32'(bif.underflow), 32'(x.u));
    endtask

    task automatic do_cmd(input string tag, input logic i, input logic j,
                          input logic c, input logic r,
                          input logic [AW-1:0] t);
        exp_t x;
        bif.incr   = i;
        bif.jump   = j;
        bif.call   = c;
        bif.ret    = r;
        bif.target = t;
        if (r) begin
            if (m_lvl > 0) begin
                m_lvl = m_lvl - 1;
                m_pc  = m_stk[m_lvl];
            end else begin
                m_unf = 1'b1;
            end
        end else if (c) begin
            if (m_lvl < DP) begin
                m_stk[m_lvl] = m_pc + 8'd1;
                m_lvl = m_lvl + 1;
                m_pc  = t;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (j) begin
            m_pc = t;
        end else if (i) begin
            m_pc = m_pc + 8'd1;
        end
        sbq.push_back(model_snap());
        @(posedge clk);
        #1;
        chk({tag, ".sbq"}, 32'(sbq.size()), 32'd1);
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            compare_now(tag, x);
        end
        bif.incr = 1'b0;
        bif.jump = 1'b0;
        bif.call = 1'b0;
        bif.ret  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        resetBar   = 1'b0;
        bif.incr   = 1'b0;
        bif.jump   = 1'b0;
        bif.call   = 1'b0;
        bif.ret    = 1'b0;
        bif.target = '0;
        model_reset();
        #12;
        compare_now("rst", model_snap());
        resetBar = 1'b1;

        for (int k = 0; k < 3; k++)
            do_cmd("incr", 1, 0, 0, 0, 8'h00);

        do_cmd("jmp_fe", 0, 1, 0, 0, 8'hFE);
        do_cmd("inc_ff", 1, 0, 0, 0, 8'h00);
        do_cmd("inc_wrap", 1, 0, 0, 0, 8'h00);

        do_cmd("jmp_10", 0, 1, 0, 0, 8'h10);
        do_cmd("call_40", 0, 0, 1, 0, 8'h40);
        do_cmd("call_80", 0, 0, 1, 0, 8'h80);
        do_cmd("ret_41", 0, 0, 0, 1, 8'h00);
        do_cmd("ret_11", 0, 0, 0, 1, 8'h00);

        do_cmd("jmp_05", 0, 1, 0, 0, 8'h05);
        for (int k = 0; k < 5; k++)
            do_cmd("call_n", 0, 0, 1, 0, 8'(8'h20 + 8'h10 * k));
        for (int k = 0; k < 5; k++)
            do_cmd("ret_n", 0, 0, 0, 1, 8'h00);

        do_cmd("call_33", 0, 0, 1, 0, 8'h33);
        do_cmd("all4", 1, 1, 1, 1, 8'h99);
        do_cmd("call_jmp", 0, 1, 1, 0, 8'h22);
        do_cmd("call_a0", 0, 0, 1, 0, 8'hA0);
        do_cmd("call_b0", 0, 0, 1, 0, 8'hB0);
        chk("pre_rst.lvl", 32'(bif.level), 32'd3);

        #2;
        resetBar = 1'b0;
        model_reset();
        #2;
        compare_now("mid_rst", model_snap());
        #2;
        resetBar = 1'b1;
        do_cmd("post_rst", 1, 0, 0, 0, 8'h00);
        do_cmd("post_call", 0, 0, 1, 0, 8'h70);
        do_cmd("post_ret", 0, 0, 0, 1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
